// File: rtl/btb_set_assoc.sv
// N-way set-associative branch target buffer: one registered lookup per cycle,
// predecode updates with round-robin victim choice, and a one-set-per-cycle flush sweep.
module btb_set_assoc #(
    parameter int ADDR_W   = 32,
    parameter int SETS     = 256,
    parameter int WAYS     = 2,
    parameter int OFFSET_W = 5,
    parameter int CNT_W    = 4,
    parameter int TYPE_W   = 3,
    localparam int IDX_W   = $clog2(SETS),
    localparam int WAY_W   = $clog2(WAYS),
    localparam int TAG_W   = ADDR_W - IDX_W - OFFSET_W
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              InstPcAble,
    input  logic [ADDR_W-1:0] InstPc,
    input  logic              UpAble,
    input  logic [ADDR_W-1:0] UpPc,
    input  logic [CNT_W-1:0]  UpCnt,
    input  logic [TYPE_W-1:0] UpType,
    input  logic [ADDR_W-1:0] UpTaget,
    input  logic              FlushReq,
    output logic              FlushBusy,
    output logic              InstNextAble,
    output logic              InstNextHit,
    output logic [ADDR_W-1:0] InstNextPc,
    output logic [TYPE_W-1:0] InstNextType,
    output logic [CNT_W-1:0]  InstNextCnt,
    output logic [WAY_W-1:0]  InstNextWay
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   fc_q, fc_d;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    valid_d [SETS];
    logic [WAY_W-1:0]   rr_q [SETS];
    logic [WAY_W-1:0]   rr_d [SETS];

    // Payload storage has no reset: valid bits alone decide whether an entry is live.
    logic [TAG_W-1:0]   tag_mem [SETS][WAYS];
    logic [ADDR_W-1:0]  tgt_mem [SETS][WAYS];
    logic [TYPE_W-1:0]  type_mem [SETS][WAYS];
    logic [CNT_W-1:0]   cnt_mem [SETS][WAYS];

    logic               able_q, able_d, hit_q, hit_d, busy_q, busy_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [TYPE_W-1:0]  type_q, type_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAY_W-1:0]   way_q, way_d;

    logic [IDX_W-1:0]   lk_idx_s, up_idx_s;
    logic [TAG_W-1:0]   lk_tag_s, up_tag_s;
    logic [WAYS-1:0]    lk_match_s, up_match_s, up_inv_s;
    logic               lk_hit_s;
    logic [WAY_W-1:0]   lk_way_s, up_match_way_s, up_inv_way_s, wr_way_s;
    logic               wr_en_s;
    logic [ADDR_W-1:0]  miss_pc_s;
    logic               unused_ok_s;

    assign lk_idx_s    = InstPc[OFFSET_W+IDX_W-1:OFFSET_W];
    assign lk_tag_s    = InstPc[ADDR_W-1:OFFSET_W+IDX_W];
    assign up_idx_s    = UpPc[OFFSET_W+IDX_W-1:OFFSET_W];
    assign up_tag_s    = UpPc[ADDR_W-1:OFFSET_W+IDX_W];
    assign miss_pc_s   = {InstPc[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}} + (ADDR_W'(1) << OFFSET_W);
    assign unused_ok_s = ^{InstPc[OFFSET_W-1:0], UpPc[OFFSET_W-1:0]};

    // Tag compare for lookup and update; descending scan leaves the lowest matching way.
    always_comb begin
        lk_way_s       = '0;
        up_match_way_s = '0;
        up_inv_way_s   = '0;
        for (int w = 0; w < WAYS; w++) begin
            lk_match_s[w] = valid_q[lk_idx_s][w] && (tag_mem[lk_idx_s][w] == lk_tag_s);
            up_match_s[w] = valid_q[up_idx_s][w] && (tag_mem[up_idx_s][w] == up_tag_s);
            up_inv_s[w]   = ~valid_q[up_idx_s][w];
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            lk_way_s       = lk_match_s[w] ? WAY_W'(w) : lk_way_s;
            up_match_way_s = up_match_s[w] ? WAY_W'(w) : up_match_way_s;
            up_inv_way_s   = up_inv_s[w]   ? WAY_W'(w) : up_inv_way_s;
        end
        lk_hit_s = (|lk_match_s) && (state_q == ST_IDLE);
    end

    // Lookup result: registered next cycle, held when no request is presented.
    always_comb begin
        able_d = InstPcAble;
        hit_d  = hit_q;
        pc_d   = pc_q;
        type_d = type_q;
        cnt_d  = cnt_q;
        way_d  = way_q;
        if (InstPcAble) begin
            if (lk_hit_s) begin
                hit_d  = 1'b1;
                pc_d   = tgt_mem[lk_idx_s][lk_way_s];
                type_d = type_mem[lk_idx_s][lk_way_s];
                cnt_d  = cnt_mem[lk_idx_s][lk_way_s];
                way_d  = lk_way_s;
            end else begin
                hit_d  = 1'b0;
                pc_d   = miss_pc_s;
                type_d = '0;
                cnt_d  = '0;
                way_d  = '0;
            end
        end else begin
            hit_d = hit_q;
        end
    end

    // Flush FSM plus update victim choice; valid/rr only change here.
    always_comb begin
        state_d  = state_q;
        fc_d     = fc_q;
        valid_d  = valid_q;
        rr_d     = rr_q;
        wr_en_s  = 1'b0;
        wr_way_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (FlushReq) begin
                    state_d = ST_FLUSH;
                    fc_d    = '0;
                end else if (UpAble) begin
                    wr_en_s = 1'b1;
                    if (|up_match_s) begin
                        wr_way_s = up_match_way_s;
                    end else if (|up_inv_s) begin
                        wr_way_s = up_inv_way_s;
                    end else begin
                        wr_way_s           = rr_q[up_idx_s];
                        rr_d[up_idx_s]     = rr_q[up_idx_s] + WAY_W'(1);
                    end
                    valid_d[up_idx_s][wr_way_s] = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                valid_d[fc_q] = '0;
                rr_d[fc_q]    = '0;
                fc_d          = fc_q + IDX_W'(1);
                if (fc_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_FLUSH);
    end

    // Control state and output registers.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_q <= ST_IDLE;
            fc_q    <= '0;
            valid_q <= '{default: '0};
            rr_q    <= '{default: '0};
            able_q  <= 1'b0;
            hit_q   <= 1'b0;
            busy_q  <= 1'b0;
            pc_q    <= '0;
            type_q  <= '0;
            cnt_q   <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            able_q  <= able_d;
            hit_q   <= hit_d;
            busy_q  <= busy_d;
            pc_q    <= pc_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            way_q   <= way_d;
        end
    end

    // Entry payload write for an accepted update.
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            tag_mem[up_idx_s][wr_way_s]  <= up_tag_s;
            tgt_mem[up_idx_s][wr_way_s]  <= UpTaget;
            type_mem[up_idx_s][wr_way_s] <= UpType;
            cnt_mem[up_idx_s][wr_way_s]  <= UpCnt;
        end
    end

    assign FlushBusy    = busy_q;
    assign InstNextAble = able_q;
    assign InstNextHit  = hit_q;
    assign InstNextPc   = pc_q;
    assign InstNextType = type_q;
    assign InstNextCnt  = cnt_q;
    assign InstNextWay  = way_q;

endmodule
